// File: rtl/shift_seq_gen.sv
// Run-time selectable feedback shift-register sequence generator (ring / Johnson / XNOR-LFSR / hold)
// with parallel load, registered carry-out, wrap pulse and measured cycle period.
module shift_seq_gen #(
  parameter int                WIDTH = 3,
  parameter logic [WIDTH-1:0]  SEED  = WIDTH'(1),
  parameter logic [WIDTH-1:0]  TAPS  = WIDTH'(3'b110)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             c,
  output logic             wrap,
  output logic [WIDTH:0]   period
);

  localparam logic [1:0]   M_RING = 2'b00;
  localparam logic [1:0]   M_JOHN = 2'b01;
  localparam logic [1:0]   M_LFSR = 2'b10;
  localparam logic [1:0]   M_HOLD = 2'b11;
  localparam logic [WIDTH:0] CNT_ONE = (WIDTH+1)'(1);

  logic [WIDTH-1:0] q_q, q_d, seed_q, seed_d, q_shift;
  logic [WIDTH:0]   cnt_q, cnt_d, cnt_inc, period_q, period_d;
  logic [1:0]       mode_sh_q, mode_sh_d;
  logic             c_q, c_d, wrap_q, wrap_d;
  logic             fb, mode_chg, shift_en;

  always_comb begin
    fb = 1'b0;
    case (mode)
      M_RING:  fb = q_q[WIDTH-1];
      M_JOHN:  fb = ~q_q[WIDTH-1];
      M_LFSR:  fb = ~^(q_q & TAPS);
      default: fb = 1'b0;
    endcase
  end

  assign q_shift  = {q_q[WIDTH-2:0], fb};
  assign mode_chg = (mode != mode_sh_q);
  assign shift_en = en && (mode != M_HOLD);
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  always_comb begin
    q_d       = q_q;
    seed_d    = seed_q;
    cnt_d     = cnt_q;
    c_d       = 1'b0;
    wrap_d    = 1'b0;
    period_d  = period_q;
    mode_sh_d = mode_sh_q;
    if (load) begin
      q_d    = load_val;
      seed_d = load_val;
      cnt_d  = '0;
    end else begin
      // A mode switch restarts the period measurement from wherever q currently is.
      if (mode_chg) begin
        seed_d    = q_q;
        cnt_d     = '0;
        mode_sh_d = mode;
      end
      if (shift_en) begin
        q_d = q_shift;
        c_d = q_q[WIDTH-1];
        if (!mode_chg && (q_shift == seed_q)) begin
          wrap_d   = 1'b1;
          period_d = cnt_inc;
          cnt_d    = '0;
        end else begin
          cnt_d = mode_chg ? CNT_ONE : cnt_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q       <= SEED;
      seed_q    <= SEED;
      cnt_q     <= '0;
      c_q       <= 1'b0;
      wrap_q    <= 1'b0;
      period_q  <= '0;
      mode_sh_q <= mode;
    end else begin
      q_q       <= q_d;
      seed_q    <= seed_d;
      cnt_q     <= cnt_d;
      c_q       <= c_d;
      wrap_q    <= wrap_d;
      period_q  <= period_d;
      mode_sh_q <= mode_sh_d;
    end
  end

  assign q      = q_q;
  assign c      = c_q;
  assign wrap   = wrap_q;
  assign period = period_q;

endmodule

// File: tb/tb_shift_seq_gen.sv
// Scoreboard bench for shift_seq_gen: directed sequences plus random traffic against an
// integer-arithmetic reference model; a monitor checks every cycle's registered outputs.
module tb_shift_seq_gen;
  localparam int W = 4;
  localparam logic [W-1:0] SD = 4'b0001;
  localparam logic [W-1:0] TP = 4'b1100;
  localparam int MAXC = (1 << (W+1)) - 1;
  localparam int MASK = (1 << W) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1, en = 1'b0, load = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [W-1:0] load_val = '0;
  logic [W-1:0] q;
  logic c, wrap;
  logic [W:0] period;

  always #5 clk = ~clk;

  shift_seq_gen #(.WIDTH(W), .SEED(SD), .TAPS(TP)) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode), .load(load),
    .load_val(load_val), .q(q), .c(c), .wrap(wrap), .period(period)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic         c;
    logic         wrap;
    logic [W:0]   period;
  } exp_t;

  exp_t sb[$];
  int vectors = 0, errors = 0;

  // reference model state
  int m_q, m_seed, m_cnt, m_per, m_sh, m_c, m_w;

  function automatic int next_val(input int v, input int md);
    int msb;
    msb = (v >> (W-1)) & 1;
    case (md)
      0:       return ((v << 1) | msb) & MASK;
      1:       return ((v << 1) | (1 - msb)) & MASK;
      default: return ((v << 1) | (1 - ($countones(v & int'(TP)) % 2))) & MASK;
    endcase
  endfunction

  // Drive one cycle at the current negedge, update the model, then wait for the next negedge.
  task automatic step(input logic r, input logic e, input logic [1:0] md,
                      input logic l, input logic [W-1:0] lv);
    exp_t x;
    bit chg;
    int nq;
    reset = r; en = e; mode = md; load = l; load_val = lv;
    if (r) begin
      m_q = int'(SD); m_seed = int'(SD); m_cnt = 0; m_per = 0; m_c = 0; m_w = 0; m_sh = int'(md);
    end else if (l) begin
      m_q = int'(lv); m_seed = int'(lv); m_cnt = 0; m_c = 0; m_w = 0;
    end else begin
      chg = (int'(md) != m_sh);
      if (chg) begin m_seed = m_q; m_cnt = 0; m_sh = int'(md); end
      m_c = 0; m_w = 0;
      if (e && md != 2'b11) begin
        nq  = next_val(m_q, int'(md));
        m_c = (m_q >> (W-1)) & 1;
        if (!chg && nq == m_seed) begin
          m_w = 1; m_per = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1; m_cnt = 0;
        end else begin
          m_cnt = (m_cnt + 1 > MAXC) ? MAXC : m_cnt + 1;
        end
        m_q = nq;
      end
    end
    x.q = W'(m_q); x.c = m_c[0]; x.wrap = m_w[0]; x.period = (W+1)'(m_per);
    sb.push_back(x);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: one registered output set per clock
  initial begin
    exp_t e, g;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        g = '{q: q, c: c, wrap: wrap, period: period};
        vectors++;
        if (g !== e) begin
          errors++;
          $display("FAIL sb t=%0t: got q=%b c=%b wrap=%b period=%0d expected q=%b c=%b wrap=%b period=%0d",
                   $time, g.q, g.c, g.wrap, g.period, e.q, e.c, e.wrap, e.period);
        end
      end
    end
  end

  initial begin
    bit seen [16];
    int distinct, qh;
    @(negedge clk);
    step(1, 0, 2'b00, 0, '0);
    step(1, 0, 2'b00, 0, '0);
    chk("reset_q", int'(q), 1);
    chk("reset_period", int'(period), 0);

    // ring from reset: 0010,0100,1000,0001
    for (int i = 0; i < 4; i++) step(0, 1, 2'b00, 0, '0);
    chk("ring_wrap", int'(wrap), 1);
    chk("ring_c", int'(c), 1);
    chk("ring_period", int'(period), W);

    // Johnson from 0000
    step(0, 0, 2'b01, 1, 4'b0000);
    for (int i = 0; i < 8; i++) step(0, 1, 2'b01, 0, '0);
    chk("john_wrap", int'(wrap), 1);
    chk("john_period", int'(period), 2*W);

    // LFSR from 0000: 15 distinct states, never all-ones
    step(0, 0, 2'b10, 1, 4'b0000);
    distinct = 0;
    for (int i = 0; i < 15; i++) begin
      step(0, 1, 2'b10, 0, '0);
      if (!seen[q]) distinct++;
      seen[q] = 1'b1;
    end
    chk("lfsr_distinct", distinct, 15);
    chk("lfsr_no_lockup", int'(seen[15]), 0);
    chk("lfsr_wrap", int'(wrap), 1);
    chk("lfsr_period", int'(period), 15);

    // lock-up state
    step(0, 1, 2'b10, 1, 4'b1111);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b10, 0, '0);
      chk("lock_wrap", int'(wrap), 1);
      chk("lock_period", int'(period), 1);
    end

    // load beats shift
    step(0, 1, 2'b10, 1, 4'b0101);
    chk("load_prio_q", int'(q), 5);
    chk("load_prio_period", int'(period), 1);

    // Johnson with a 3-cycle hold, then reseed on return to 01
    for (int i = 0; i < 3; i++) step(0, 1, 2'b01, 0, '0);
    qh = int'(q);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 2'b11, 0, '0);
      chk("hold_q", int'(q), qh);
    end
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 2'b01, 0, '0);
      chk("hold_nowrap", int'(wrap), 0);
    end
    step(0, 1, 2'b01, 0, '0);
    chk("hold_wrap", int'(wrap), 1);
    chk("hold_period", int'(period), 2*W);

    // reset mid-sequence
    step(1, 0, 2'b01, 0, '0);
    step(0, 1, 2'b01, 0, '0);
    chk("mid_q", int'(q), 3);
    step(1, 1, 2'b01, 0, '0);
    chk("rst_q", int'(q), 1);
    chk("rst_c", int'(c), 0);
    chk("rst_period", int'(period), 0);
    step(0, 1, 2'b01, 0, '0);
    chk("restart_q", int'(q), 3);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(99) < 2), ($urandom_range(99) < 85),
           ($urandom_range(99) < 90) ? mode : 2'($urandom_range(3)),
           ($urandom_range(99) < 4), W'($urandom));
    end

    for (int i = 0; i < 3 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
